// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: hazard FSM encodings, the $zero register index
// and the forwarding-mux select codes.
package mips_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // True when a producer's destination feeds a source of the ID instruction; $zero never does.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating up-counter of stall cycles; holds at all ones instead of wrapping.
module hazard_stall_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / branch-operand hazard detection with a RUN/HOLD FSM for 2-cycle stalls.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_detection_unit
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           IF_ID_Rs,
  input  logic [4:0]           IF_ID_Rt,
  input  logic                 IF_ID_UsesRt,
  input  logic                 IF_ID_Branch,
  input  logic                 ID_EX_MemRead,
  input  logic                 ID_EX_RegWrite,
  input  logic [4:0]           ID_EX_Rd,
  input  logic                 EX_MEM_MemRead,
  input  logic [4:0]           EX_MEM_Rd,
  input  logic                 BranchTaken,
  input  logic                 Jump,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Flush,
  output logic                 IF_ID_Flush,
  output logic [CNT_WIDTH-1:0] StallCount
);

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       match_ex;
  logic       match_mem;
  logic       load_use;
  logic       branch_alu;
  logic       branch_load2;
  logic       branch_load1;
  logic       hazard;
  logic       stall;

  assign match_ex  = reg_match(ID_EX_Rd,  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
  assign match_mem = reg_match(EX_MEM_Rd, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);

  assign load_use     = ID_EX_MemRead && match_ex;
  assign branch_alu   = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && match_ex;
  assign branch_load2 = IF_ID_Branch && ID_EX_MemRead && match_ex;
  assign branch_load1 = IF_ID_Branch && EX_MEM_MemRead && match_mem;
  assign hazard       = load_use || branch_alu || branch_load2 || branch_load1;

  // Reset forces the pipeline to run freely even if a HOLD is pending.
  assign stall = !reset && ((state_reg == ST_HOLD) || hazard);

  always_comb begin
    state_next = ST_RUN;
    if ((state_reg == ST_RUN) && branch_load2) begin
      state_next = ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = !reset && (BranchTaken || Jump) && !stall;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] count_raw;

  hazard_stall_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .count(count_raw)
  );

  // Hide the pre-reset value during the reset cycle itself.
  assign StallCount = reset ? '0 : count_raw;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; counter expectations follow
// HAZARD_STALL_CNT_EN so the bench serves both builds.
module tb_hazard_detection_unit;
  import mips_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    IF_ID_Rs, IF_ID_Rt, ID_EX_Rd, EX_MEM_Rd;
  logic          IF_ID_UsesRt, IF_ID_Branch, ID_EX_MemRead, ID_EX_RegWrite;
  logic          EX_MEM_MemRead, BranchTaken, Jump;
  logic          PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush;
  logic [CW-1:0] StallCount;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  hazard_detection_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .IF_ID_Branch(IF_ID_Branch), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Rd(ID_EX_Rd),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
    .BranchTaken(BranchTaken), .Jump(Jump),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
    .IF_ID_Flush(IF_ID_Flush), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  task automatic clear_inputs();
    IF_ID_Rs = 0; IF_ID_Rt = 0; IF_ID_UsesRt = 0; IF_ID_Branch = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Rd = 0;
    EX_MEM_MemRead = 0; EX_MEM_Rd = 0; BranchTaken = 0; Jump = 0;
  endtask

  // Advance one clock; exp_stall is the bench's expectation for the cycle just ended.
  task automatic tick(input logic exp_stall);
    @(posedge clk);
`ifdef HAZARD_STALL_CNT_EN
    if (reset) exp_cnt = 0;
    else if (exp_stall && exp_cnt < 15) exp_cnt = exp_cnt + 1;
`else
    exp_cnt = 0;
`endif
    #1;
  endtask

  // Settle the combinational outputs and compare against the expected stall/flush pair.
  task automatic expect_out(input string tag, input logic exp_stall, input logic exp_flush);
    #1;
    check({tag, ".PCWrite"},     PCWrite,     !exp_stall);
    check({tag, ".IF_ID_Write"}, IF_ID_Write, !exp_stall);
    check({tag, ".ID_EX_Flush"}, ID_EX_Flush, exp_stall);
    check({tag, ".IF_ID_Flush"}, IF_ID_Flush, exp_flush);
  endtask

  task automatic expect_cnt(input string tag);
    check({tag, ".StallCount"}, StallCount, exp_cnt);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    // Reset cycle with a live hazard and redirect: reset wins.
    ID_EX_MemRead = 1; ID_EX_Rd = 8; IF_ID_Rs = 8; BranchTaken = 1;
    expect_out("reset", 0, 0);
    check("reset.StallCount", StallCount, 0);
    tick(0);
    reset = 1'b0;
    clear_inputs();
    expect_out("idle", 0, 0);
    check("idle.state", dut.state_reg, ST_RUN);
    expect_cnt("idle");

    // Scenario 1: load-use on Rs
    ID_EX_MemRead = 1; ID_EX_Rd = 8; IF_ID_Rs = 8;
    expect_out("s1.stall", 1, 0);
    tick(1); clear_inputs();
    expect_out("s1.after", 0, 0);
    expect_cnt("s1.after");

    // Rt match only counts when the instruction reads Rt
    ID_EX_MemRead = 1; ID_EX_Rd = 12; IF_ID_Rt = 12; IF_ID_Rs = 3; IF_ID_UsesRt = 0;
    expect_out("rt.unused", 0, 0);
    IF_ID_UsesRt = 1;
    expect_out("rt.used", 1, 0);
    tick(1); clear_inputs();

    // Branch needs an ALU result from EX: single stall, no HOLD
    IF_ID_Branch = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 5; IF_ID_Rs = 5;
    expect_out("balu.stall", 1, 0);
    tick(1); clear_inputs();
    expect_out("balu.after", 0, 0);
    check("balu.state", dut.state_reg, ST_RUN);
    IF_ID_Branch = 1; ID_EX_RegWrite = 0; ID_EX_Rd = 5; IF_ID_Rs = 5;
    expect_out("balu.nowrite", 0, 0);
    clear_inputs();

    // Scenario 2: branch after load in EX -> RUN stall then HOLD stall
    IF_ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_Rd = 9; IF_ID_Rt = 9; IF_ID_UsesRt = 1;
    expect_out("s2.run", 1, 0);
    expect_cnt("s2.before");
    tick(1); clear_inputs();
    expect_out("s2.hold", 1, 0);
    check("s2.state", dut.state_reg, ST_HOLD);
    tick(1);
    expect_out("s2.after", 0, 0);
    expect_cnt("s2.after");

    // Branch after load in MEM -> single stall
    IF_ID_Branch = 1; EX_MEM_MemRead = 1; EX_MEM_Rd = 7; IF_ID_Rs = 7;
    expect_out("bmem.stall", 1, 0);
    tick(1); clear_inputs();
    expect_out("bmem.after", 0, 0);

    // Scenario 3: $zero never creates a hazard
    ID_EX_MemRead = 1; ID_EX_Rd = 0; IF_ID_Rs = 0;
    expect_out("s3.zero", 0, 0);
    IF_ID_Branch = 1; EX_MEM_MemRead = 1; EX_MEM_Rd = 0; ID_EX_RegWrite = 1;
    expect_out("s3.zero_br", 0, 0);
    clear_inputs();

    // Scenario 4: stall suppresses redirect flush
    BranchTaken = 1; ID_EX_MemRead = 1; ID_EX_Rd = 4; IF_ID_Rs = 4;
    expect_out("s4.stalled", 1, 0);
    tick(1);
    ID_EX_MemRead = 0; ID_EX_Rd = 0;
    expect_out("s4.redirect", 0, 1);
    BranchTaken = 0; Jump = 1;
    expect_out("s4.jump", 0, 1);
    tick(0); clear_inputs();

    // Scenario 5: reset in the HOLD cycle aborts the HOLD
    IF_ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_Rd = 10; IF_ID_Rs = 10;
    tick(1); clear_inputs();
    check("s5.in_hold", dut.state_reg, ST_HOLD);
    reset = 1'b1;
    expect_out("s5.reset", 0, 0);
    check("s5.reset.StallCount", StallCount, 0);
    tick(0);
    reset = 1'b0;
    expect_out("s5.after", 0, 0);
    check("s5.state", dut.state_reg, ST_RUN);
    check("s5.StallCount", StallCount, 0);
    expect_cnt("s5.model");

    // Scenario 6: 20 continuous stall cycles saturate a 4-bit counter
    ID_EX_MemRead = 1; ID_EX_Rd = 6; IF_ID_Rs = 6;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 14 || i == 19) expect_cnt($sformatf("s6.cycle%0d", i));
    end
    expect_out("s6.still_stalled", 1, 0);
`ifdef HAZARD_STALL_CNT_EN
    check("s6.saturated", StallCount, 15);
`else
    check("s6.tied_zero", StallCount, 0);
`endif
    clear_inputs();
    tick(0);
    expect_out("s6.release", 0, 0);
    expect_cnt("s6.release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
